// File: rtl/step_phase_ctrl.sv
// ============================================================================
// Module  : step_phase_ctrl
// Brief   : Expands each CPU cycle into a programmable train of phase strobes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module step_phase_ctrl #(
  parameter int CNT_W     = 6,
  parameter int T_RD_DEF  = 10,
  parameter int T_MEM_DEF = 5,
  parameter int T_WB_DEF  = 8,
  parameter int T_END_DEF = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_req,
  input  logic             run_mode,
  input  logic             halt,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             busy,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             pc_en,
  output logic             rd_stb,
  output logic             mem_stb,
  output logic             wb_stb,
  output logic             cycle_done,
  output logic             pending,
  output logic             cfg_err,
  output logic [15:0]      step_count
);

  localparam logic [CNT_W-1:0] C_ZERO    = '0;
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MIN_END = CNT_W'(3);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PHASE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             step_q;
  logic             pending_q, pending_d;
  logic             cfg_err_q, cfg_err_d;
  logic [15:0]      count_q, count_d;
  logic [CNT_W-1:0] t_rd_q, t_rd_d;
  logic [CNT_W-1:0] t_mem_q, t_mem_d;
  logic [CNT_W-1:0] t_wb_q, t_wb_d;
  logic [CNT_W-1:0] t_end_q, t_end_d;
  logic             pc_en_q, pc_en_d;
  logic             rd_q, rd_d;
  logic             mem_q, mem_d;
  logic             wb_q, wb_d;
  logic             done_q, done_d;

  logic             step_edge;
  logic             launch;
  logic             at_end;
  logic             busy_d;
  logic [CNT_W-1:0] n_rd, n_mem, n_wb, n_end;
  logic             cand_ok;
  logic             cfg_ok;

  assign step_edge = step_req & ~step_q;
  assign at_end    = (state_q == ST_PHASE) && (phase_q == t_end_q);
  assign launch    = (state_q == ST_IDLE) && !halt && (step_edge || pending_q || run_mode);

  // Candidate offset set as it would look after the requested write.
  always_comb begin
    n_rd  = t_rd_q;
    n_mem = t_mem_q;
    n_wb  = t_wb_q;
    n_end = t_end_q;
    case (cfg_sel)
      2'd0:    n_rd  = cfg_data;
      2'd1:    n_mem = cfg_data;
      2'd2:    n_wb  = cfg_data;
      default: n_end = cfg_data;
    endcase
  end

  assign cand_ok = (n_rd  != C_ZERO) && (n_rd  < n_end) &&
                   (n_mem != C_ZERO) && (n_mem < n_end) &&
                   (n_wb  != C_ZERO) && (n_wb  < n_end) &&
                   (n_rd != n_mem) && (n_rd != n_wb) && (n_mem != n_wb) &&
                   (n_end >= C_MIN_END);
  assign cfg_ok  = cand_ok && (state_q == ST_IDLE) && !launch;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pending_d = pending_q;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d   = ST_PHASE;
          phase_d   = C_ZERO;
          pending_d = 1'b0;
        end
      end
      default: begin
        if (at_end) begin
          count_d   = count_q + 16'd1;
          pending_d = 1'b0;
          phase_d   = C_ZERO;
          // A step edge landing on the last phase restarts just like a queued one.
          if (halt || !(run_mode || pending_q || step_edge)) begin
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = phase_q + C_ONE;
          if (step_edge) begin
            pending_d = 1'b1;
          end
        end
      end
    endcase
    if (halt) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    cfg_err_d = cfg_err_q;
    t_rd_d    = t_rd_q;
    t_mem_d   = t_mem_q;
    t_wb_d    = t_wb_q;
    t_end_d   = t_end_q;
    if (cfg_we) begin
      cfg_err_d = !cfg_ok;
      if (cfg_ok) begin
        t_rd_d  = n_rd;
        t_mem_d = n_mem;
        t_wb_d  = n_wb;
        t_end_d = n_end;
      end
    end
  end

  // Strobes are precomputed from the next phase so they line up with phase_cnt.
  always_comb begin
    busy_d  = (state_d == ST_PHASE);
    pc_en_d = busy_d && (phase_d == C_ZERO);
    rd_d    = busy_d && (phase_d == t_rd_q);
    mem_d   = busy_d && (phase_d == t_mem_q);
    wb_d    = busy_d && (phase_d == t_wb_q);
    done_d  = busy_d && (phase_d == t_end_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= C_ZERO;
      step_q    <= 1'b0;
      pending_q <= 1'b0;
      cfg_err_q <= 1'b0;
      count_q   <= 16'd0;
      t_rd_q    <= CNT_W'(T_RD_DEF);
      t_mem_q   <= CNT_W'(T_MEM_DEF);
      t_wb_q    <= CNT_W'(T_WB_DEF);
      t_end_q   <= CNT_W'(T_END_DEF);
      pc_en_q   <= 1'b0;
      rd_q      <= 1'b0;
      mem_q     <= 1'b0;
      wb_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_req;
      pending_q <= pending_d;
      cfg_err_q <= cfg_err_d;
      count_q   <= count_d;
      t_rd_q    <= t_rd_d;
      t_mem_q   <= t_mem_d;
      t_wb_q    <= t_wb_d;
      t_end_q   <= t_end_d;
      pc_en_q   <= pc_en_d;
      rd_q      <= rd_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      done_q    <= done_d;
    end
  end

  assign busy       = (state_q == ST_PHASE);
  assign phase_cnt  = phase_q;
  assign pc_en      = pc_en_q;
  assign rd_stb     = rd_q;
  assign mem_stb    = mem_q;
  assign wb_stb     = wb_q;
  assign cycle_done = done_q;
  assign pending    = pending_q;
  assign cfg_err    = cfg_err_q;
  assign step_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_step_phase_ctrl.sv
// ============================================================================
// Module  : tb_step_phase_ctrl
// Brief   : Vector table, directed corner sequences and random run vs a model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_step_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, step_req, run_mode, halt, cfg_we;
  logic [1:0]  cfg_sel;
  logic [5:0]  cfg_data;
  logic        busy, pc_en, rd_stb, mem_stb, wb_stb, cycle_done, pending, cfg_err;
  logic [5:0]  phase_cnt;
  logic [15:0] step_count;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: phase index (-1 when idle) plus offsets in spec order.
  int          m_phase;
  bit          m_pending, m_err, m_step_q;
  logic [15:0] m_count;
  int          m_off[4];

  always #5 clk = ~clk;

  step_phase_ctrl dut (
    .clk(clk), .rst_n(rst_n), .step_req(step_req), .run_mode(run_mode),
    .halt(halt), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .busy(busy), .phase_cnt(phase_cnt), .pc_en(pc_en), .rd_stb(rd_stb),
    .mem_stb(mem_stb), .wb_stb(wb_stb), .cycle_done(cycle_done),
    .pending(pending), .cfg_err(cfg_err), .step_count(step_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cfg_valid(input int o[4]);
    return o[0] >= 1 && o[1] >= 1 && o[2] >= 1 &&
           o[0] < o[3] && o[1] < o[3] && o[2] < o[3] &&
           o[0] != o[1] && o[0] != o[2] && o[1] != o[2] && o[3] >= 3;
  endfunction

  task automatic model_update();
    bit e, idle, launch, ok;
    int tmp[4];
    if (!rst_n) begin
      m_phase = -1; m_pending = 0; m_err = 0; m_count = 0; m_step_q = 0;
      m_off = '{10, 5, 8, 12};
      return;
    end
    idle   = (m_phase < 0);
    e      = step_req && !m_step_q;
    launch = idle && !halt && (e || m_pending || run_mode);
    if (cfg_we) begin
      tmp = m_off;
      tmp[cfg_sel] = int'(cfg_data);
      ok = idle && !launch && cfg_valid(tmp);
      if (ok) m_off = tmp;
      m_err = !ok;
    end
    if (idle) begin
      if (launch) begin m_phase = 0; m_pending = 0; end
    end else if (m_phase == m_off[3]) begin
      m_count = m_count + 16'd1;
      if (!halt && (run_mode || m_pending || e)) m_phase = 0;
      else m_phase = -1;
      m_pending = 0;
    end else begin
      m_phase++;
      if (e) m_pending = 1;
    end
    if (halt) m_pending = 0;
    m_step_q = step_req;
  endtask

  task automatic model_compare();
    bit b;
    b = (m_phase >= 0);
    chk("m_busy", busy, b);
    chk("m_phase", phase_cnt, b ? m_phase : 0);
    chk("m_strobes", {pc_en, rd_stb, mem_stb, wb_stb, cycle_done},
        {b && m_phase == 0, b && m_phase == m_off[0], b && m_phase == m_off[1],
         b && m_phase == m_off[2], b && m_phase == m_off[3]});
    chk("m_pending", pending, m_pending);
    chk("m_cfg_err", cfg_err, m_err);
    chk("m_count", step_count, m_count);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    model_compare();
  endtask

  task automatic do_reset();
    rst_n = 0; step_req = 0; run_mode = 0; halt = 0; cfg_we = 0; cfg_sel = 0; cfg_data = 0;
    tick();
    rst_n = 1;
  endtask

  function automatic logic strobe(input int which);
    case (which)
      0: return pc_en;
      1: return rd_stb;
      2: return mem_stb;
      3: return wb_stb;
      default: return cycle_done;
    endcase
  endfunction

  task automatic wait_strobe(input string nm, input int which, input int max);
    for (int i = 0; i < max; i++) begin
      if (strobe(which)) break;
      tick();
    end
    chk(nm, strobe(which), 1);
  endtask

  typedef struct {
    logic        rst_n;
    logic        step;
    logic        exp_busy;
    int          exp_phase;
    logic [4:0]  exp_strb;
    logic [15:0] exp_count;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Default offsets 10/5/8/12: one step held high, then two idle clocks.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 5'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 0, 5'b0, 16'd0};
    for (int p = 0; p <= 12; p++)
      tbl[p+2] = '{1'b1, 1'b1, 1'b1, p,
                   {p == 0, p == 10, p == 5, p == 8, p == 12}, 16'd0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 0, 5'b0, 16'd1};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 0, 5'b0, 16'd1};

    rst_n = 0; step_req = 0; run_mode = 0; halt = 0; cfg_we = 0; cfg_sel = 0; cfg_data = 0;
    m_phase = -1; m_pending = 0; m_err = 0; m_count = 0; m_step_q = 0;
    m_off = '{10, 5, 8, 12};

    for (int i = 0; i < 17; i++) begin
      rst_n = tbl[i].rst_n;
      step_req = tbl[i].step;
      tick();
      chk("tbl_busy", busy, tbl[i].exp_busy);
      chk("tbl_phase", phase_cnt, tbl[i].exp_phase);
      chk("tbl_strobes", {pc_en, rd_stb, mem_stb, wb_stb, cycle_done}, tbl[i].exp_strb);
      chk("tbl_count", step_count, tbl[i].exp_count);
    end

    // Queued step, plus a dropped third edge.
    do_reset();
    step_req = 1; tick();
    step_req = 0; tick(); tick();
    step_req = 1; tick();
    chk("q_pending_set", pending, 1);
    chk("q_phase", phase_cnt, 3);
    step_req = 0; tick();
    step_req = 1; tick();
    chk("q_pending_hold", pending, 1);
    wait_strobe("q_done1", 4, 30);
    tick();
    chk("q_restart_pc", {busy, pc_en, phase_cnt}, {1'b1, 1'b1, 6'd0});
    chk("q_pending_clr", pending, 0);
    wait_strobe("q_done2", 4, 30);
    tick();
    chk("q_count", step_count, 2);
    chk("q_idle", busy, 0);

    // Free-run for three cycles, halt raised mid third cycle.
    do_reset();
    run_mode = 1;
    for (int i = 0; i < 100; i++) begin
      if (step_count == 16'd2 && phase_cnt == 6'd6) break;
      tick();
    end
    chk("run_at_p6", {step_count, phase_cnt}, {16'd2, 6'd6});
    halt = 1;
    wait_strobe("run_done", 4, 30);
    tick();
    chk("run_halt_idle", busy, 0);
    chk("run_count", step_count, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("run_no_pc", pc_en, 0);
    end
    run_mode = 0; halt = 0;

    // Reconfiguration in IDLE.
    do_reset();
    cfg_we = 1; cfg_sel = 3; cfg_data = 20; tick();
    chk("cfg_end_ok", cfg_err, 0);
    cfg_sel = 2; cfg_data = 15; tick();
    chk("cfg_wb_ok", cfg_err, 0);
    cfg_we = 0; step_req = 1; tick();
    wait_strobe("cfg_wb_seen", 3, 40);
    chk("cfg_wb_at", phase_cnt, 15);
    wait_strobe("cfg_done_seen", 4, 40);
    chk("cfg_done_at", phase_cnt, 20);
    tick(); step_req = 0;
    cfg_we = 1; cfg_sel = 1; cfg_data = 15; tick();
    chk("cfg_dup_rej", cfg_err, 1);
    cfg_we = 0; step_req = 1; tick();
    wait_strobe("cfg_mem_seen", 2, 40);
    chk("cfg_mem_kept", phase_cnt, 5);
    wait_strobe("cfg_done2", 4, 40);
    tick(); step_req = 0;

    // Writes while busy and writes colliding with a launch.
    do_reset();
    step_req = 1; tick(); tick();
    cfg_we = 1; cfg_sel = 0; cfg_data = 2; tick();
    cfg_we = 0;
    chk("busy_wr_rej", cfg_err, 1);
    wait_strobe("busy_rd_seen", 1, 30);
    chk("busy_rd_at", phase_cnt, 10);
    wait_strobe("busy_done", 4, 30);
    tick();
    step_req = 0; tick();
    step_req = 1; cfg_we = 1; cfg_sel = 0; cfg_data = 2; tick();
    cfg_we = 0;
    chk("coll_launch", busy, 1);
    chk("coll_rej", cfg_err, 1);
    wait_strobe("coll_rd_seen", 1, 30);
    chk("coll_rd_at", phase_cnt, 10);
    wait_strobe("coll_done", 4, 30);
    tick(); step_req = 0;

    // Reset in the middle of a cycle after a config change.
    do_reset();
    cfg_we = 1; cfg_sel = 3; cfg_data = 30; tick();
    cfg_we = 0; step_req = 1; tick();
    step_req = 0; tick(); tick();
    step_req = 1;
    for (int i = 0; i < 30; i++) begin
      if (phase_cnt == 6'd7) break;
      tick();
    end
    chk("rst_at_p7", {pending, phase_cnt}, {1'b1, 6'd7});
    rst_n = 0; tick();
    chk("rst_outs", {busy, phase_cnt, pc_en, rd_stb, mem_stb, wb_stb, cycle_done,
                     pending, cfg_err, step_count}, 32'd0);
    rst_n = 1; step_req = 0; tick();
    step_req = 1; tick();
    wait_strobe("rst_mem", 2, 30); chk("rst_mem_at", phase_cnt, 5);
    wait_strobe("rst_wb", 3, 30);  chk("rst_wb_at", phase_cnt, 8);
    wait_strobe("rst_rd", 1, 30);  chk("rst_rd_at", phase_cnt, 10);
    wait_strobe("rst_done", 4, 30); chk("rst_done_at", phase_cnt, 12);
    tick(); step_req = 0;

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) step_req = ~step_req;
      if ($urandom_range(0, 40) == 0) run_mode = ~run_mode;
      halt     = ($urandom_range(0, 9) == 0);
      cfg_we   = ($urandom_range(0, 6) == 0);
      cfg_sel  = 2'($urandom_range(0, 3));
      cfg_data = 6'($urandom_range(0, 24));
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/step_phase_ctrl.md
Name: step_phase_ctrl

Overview:
- Phase sequencer for the single-step/multi-cycle pipeline CPU; the board-level step pulse or free-run request enters here.
- Each CPU cycle is expanded into a programmable train of one-clock strobes on the fast clock: PC update, register-file read, data-memory write and register-file write-back.
- Phase offsets are runtime-configurable with validity checking, and the block counts completed CPU cycles for the debug display.

Parameters:
- CNT_W, 6, width of phase counter and offset registers.
- T_RD_DEF, 10, reset value of register-read strobe offset.
- T_MEM_DEF, 5, reset value of data-memory write strobe offset.
- T_WB_DEF, 8, reset value of register write-back strobe offset.
- T_END_DEF, 12, reset value of last phase; a CPU cycle lasts T_END+1 clocks.

Ports:
- clk  in  1  fast system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- step_req  in  1  step request level, synchronous to clk; its rising edge launches one CPU cycle.
- run_mode  in  1  1 = free-run, with back-to-back CPU cycles.
- halt  in  1  1 = block any new CPU cycle from starting.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  2  target select: 0 T_RD, 1 T_MEM, 2 T_WB, 3 T_END.
- cfg_data  in  CNT_W  new offset value.
- busy  out  1  high while in PHASE state.
- phase_cnt  out  CNT_W  current phase index.
- pc_en  out  1  PC update strobe.
- rd_stb  out  1  register-read strobe.
- mem_stb  out  1  data-memory write strobe.
- wb_stb  out  1  register write-back strobe.
- cycle_done  out  1  last-phase strobe.
- pending  out  1  a step is queued.
- cfg_err  out  1  sticky flag: last config write was rejected.
- step_count  out  16  count of completed CPU cycles.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state IDLE.
  - All outputs 0.
  - Offsets take their *_DEF values.
  - Edge-detect register cleared to 0.
  - Applies mid-cycle too: any sequence in progress is abandoned and strobes are low from the next clock.
- Edge detect: step_edge = step_req & ~step_req_q, where step_q is registered every clock.
- IDLE -> PHASE with phase_cnt=0 at the next posedge when any of these holds with halt=0:
  - step_edge;
  - pending=1;
  - run_mode=1.
  - Latency: step_req rising at edge E0 gives busy=1, phase_cnt=0, pc_en=1 in the cycle after E0.
- PHASE state:
  - phase_cnt increments by 1 each clock.
  - Strobes are registered and aligned with phase_cnt, each high for exactly one clock:
    - pc_en when phase_cnt==0;
    - rd_stb when ==T_RD;
    - mem_stb when ==T_MEM;
    - wb_stb when ==T_WB;
    - cycle_done when ==T_END.
- End of cycle (phase_cnt==T_END):
  - step_count increments, wrapping 0xFFFF -> 0x0000.
  - The next state is decided at the same edge:
    - halt=1 -> IDLE, and pending is cleared.
    - else run_mode=1 or pending=1 -> phase_cnt=0, with pc_en the next clock (no idle gap); pending is cleared.
    - else -> IDLE.
- pending:
  - Set by step_edge while busy.
  - Holds at most one request; further edges while pending=1 are dropped.
  - A step_edge coinciding with phase_cnt==T_END counts as pending and causes an immediate restart.
  - Cleared on launch, on halt, or on reset.
- halt:
  - Never truncates a running cycle.
  - A step_edge in IDLE with halt=1 is discarded, not queued.
- Config writes are accepted only when all of the following hold:
  - state IDLE and not launching this clock;
  - after the update, 1 <= T_RD, T_MEM, T_WB < T_END;
  - the three strobe offsets are pairwise distinct;
  - T_END >= 3.
- Config write outcome:
  - Accepted: the register updates at that edge and cfg_err clears.
  - Rejected (busy, or rule violated): the old value is kept and cfg_err sets; it stays set until the next accepted write or reset.
- Launch and cfg_we together in IDLE: launch wins and the write is rejected.
- Offsets are read only at compare time. Because writes are blocked while busy, a cycle never sees mixed offsets.

Test Plan:
- Defaults, single step_req 0->1 held high: busy for 13 clocks; pc_en@0, mem_stb@5, wb_stb@8, rd_stb@10, cycle_done@12; step_count=1; back to IDLE and stays there while step_req remains high.
- Second step_req edge at phase_cnt=3: pending=1; after cycle_done the next clock has phase_cnt=0 and pc_en=1; pending clears; step_count=2; a third edge in the same cycle is dropped.
- run_mode=1 for 3 cycles, then halt=1 raised at phase_cnt=6: the current cycle completes; busy drops after cycle_done; step_count=3; no further pc_en while halt=1.
- In IDLE, write T_END=20 then T_WB=15: both accepted, cfg_err=0, wb_stb at 15, cycle_done at 20. Then write T_MEM=15: rejected (duplicate), cfg_err=1, T_MEM stays 5.
- cfg_we during busy (T_RD=2): rejected, cfg_err=1, rd_stb stays at 10; a step_edge together with cfg_we in IDLE launches and rejects the write.
- rst_n=0 for one clock at phase_cnt=7: all outputs 0 next clock, pending=0, step_count=0, offsets back to 10/5/8/12.
